// File: rtl/sync_ram_sdp_be.sv
// Simple-dual-port block RAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register, read-valid flag and a post-reset clear sweep.
module sync_ram_sdp_be #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDRESS_WIDTH  = 10,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    RDW_MODE       = 0,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               write_enable,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   byte_en,
    input  logic [ADDRESS_WIDTH-1:0]           address_in_w,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               read_enable,
    input  logic [ADDRESS_WIDTH-1:0]           address_in_r,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               data_valid,
    output logic                               busy
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] CNT_LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_nxt;
    logic [ADDRESS_WIDTH:0]  clr_cnt, clr_cnt_nxt;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [NB-1:0]            wr_lane;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     rd_acc;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic [DATA_WIDTH-1:0]    rd_q;
    logic                     rd_v;

    // Clear sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == CNT_LAST)
                state_nxt = IDLE;
        end
    end

    assign busy = (state == CLEAR);

    // The sweep and user writes share one write port so the array still maps to block RAM.
    always_comb begin
        wr_lane = '0;
        wr_addr = address_in_w;
        wr_data = data_in;
        if (busy) begin
            wr_lane = '1;
            wr_addr = clr_cnt[ADDRESS_WIDTH-1:0];
            wr_data = CLEAR_VALUE;
        end else if (write_enable) begin
            wr_lane = byte_en;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_lane[i])
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    assign rd_acc = read_enable && !busy;

    // Transparent mode forwards the enabled lanes of a same-address write into the read.
    always_comb begin
        rd_word = mem[address_in_r];
        if ((RDW_MODE != 0) && !busy && write_enable && (address_in_w == address_in_r)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (byte_en[i])
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            rd_v <= rd_acc;
            if (rd_acc)
                rd_q <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;
            logic                  out_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                    out_v <= 1'b0;
                end else begin
                    out_v <= rd_v;
                    if (rd_v)
                        out_q <= rd_q;
                end
            end

            assign data_out   = out_q;
            assign data_valid = out_v;
        end else begin : g_no_out_reg
            assign data_out   = rd_q;
            assign data_valid = rd_v;
        end
    endgenerate

endmodule

// File: tb/tb_sync_ram_sdp_be.sv
// Directed bench for sync_ram_sdp_be: three instances (old-data/no out reg,
// transparent/out reg, no clear) share one stimulus stream.
module tb_sync_ram_sdp_be;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_enable;
    logic [3:0]  byte_en;
    logic [3:0]  address_in_w;
    logic [31:0] data_in;
    logic        read_enable;
    logic [3:0]  address_in_r;

    logic [31:0] a_do, b_do, c_do;
    logic        a_dv, b_dv, c_dv;
    logic        a_busy, b_busy, c_busy;

    int   checks = 0;
    int   errors = 0;
    int   ca, cb;
    logic va, vb;
    logic c_busy_seen = 1'b0;

    always #5 clk = ~clk;

    always @(posedge c_busy) c_busy_seen = 1'b1;

    sync_ram_sdp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(0),
                      .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)) dut_a (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .byte_en(byte_en),
        .address_in_w(address_in_w), .data_in(data_in), .read_enable(read_enable),
        .address_in_r(address_in_r), .data_out(a_do), .data_valid(a_dv), .busy(a_busy));

    sync_ram_sdp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(1),
                      .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)) dut_b (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .byte_en(byte_en),
        .address_in_w(address_in_w), .data_in(data_in), .read_enable(read_enable),
        .address_in_r(address_in_r), .data_out(b_do), .data_valid(b_dv), .busy(b_busy));

    sync_ram_sdp_be #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(0),
                      .OUT_REG(0), .CLEAR_ON_RESET(0), .CLEAR_VALUE(32'hA5A5A5A5)) dut_c (
        .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .byte_en(byte_en),
        .address_in_w(address_in_w), .data_in(data_in), .read_enable(read_enable),
        .address_in_r(address_in_r), .data_out(c_do), .data_valid(c_dv), .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        write_enable = 1'b0;
        byte_en      = 4'h0;
        address_in_w = 4'h0;
        data_in      = 32'h0;
        read_enable  = 1'b0;
        address_in_r = 4'h0;
        tick;
        tick;

        chk("rst_a_do",   a_do,   32'h0);
        chk("rst_a_dv",   a_dv,   1'b0);
        chk("rst_a_busy", a_busy, 1'b1);
        chk("rst_b_do",   b_do,   32'h0);
        chk("rst_b_dv",   b_dv,   1'b0);
        chk("rst_b_busy", b_busy, 1'b1);
        chk("rst_c_busy", c_busy, 1'b0);

        // Sweep with a read and a write held active the whole time
        read_enable  = 1'b1;
        address_in_r = 4'd3;
        write_enable = 1'b1;
        byte_en      = 4'hF;
        address_in_w = 4'd2;
        data_in      = 32'h12345678;
        rst_n        = 1'b1;
        ca = 0; cb = 0; va = 1'b0; vb = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            va |= a_dv;
            vb |= b_dv;
            tick;
        end
        va |= a_dv;
        vb |= b_dv;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        chk("sweep_a_busy_cycles", ca, 16);
        chk("sweep_b_busy_cycles", cb, 16);
        chk("sweep_a_busy_end", a_busy, 1'b0);
        chk("sweep_b_busy_end", b_busy, 1'b0);
        chk("sweep_a_no_valid", va, 1'b0);
        chk("sweep_b_no_valid", vb, 1'b0);

        // Read back every cleared word
        for (int i = 0; i < 16; i++) begin
            address_in_r = 4'(i);
            read_enable  = 1'b1;
            tick;
            chk("clr_a_do", a_do, 32'hA5A5A5A5);
            chk("clr_a_dv", a_dv, 1'b1);
            if (i > 0) begin
                chk("clr_b_do", b_do, 32'hA5A5A5A5);
                chk("clr_b_dv", b_dv, 1'b1);
            end
        end
        read_enable = 1'b0;
        tick;
        chk("clr_b_last_do", b_do, 32'hA5A5A5A5);
        chk("clr_b_last_dv", b_dv, 1'b1);
        chk("clr_a_idle_dv", a_dv, 1'b0);

        // Byte enables
        write_enable = 1'b1;
        address_in_w = 4'd5;
        byte_en      = 4'b1111;
        data_in      = 32'h11223344;
        tick;
        byte_en      = 4'b0101;
        data_in      = 32'hAABBCCDD;
        tick;
        write_enable = 1'b0;
        read_enable  = 1'b1;
        address_in_r = 4'd5;
        tick;
        read_enable  = 1'b0;
        chk("be_a_do", a_do, 32'h11BB33DD);
        chk("be_a_dv", a_dv, 1'b1);
        chk("be_b_dv_early", b_dv, 1'b0);
        tick;
        chk("be_a_dv_pulse", a_dv, 1'b0);
        chk("be_a_do_hold", a_do, 32'h11BB33DD);
        chk("be_b_do", b_do, 32'h11BB33DD);
        chk("be_b_dv", b_dv, 1'b1);
        tick;
        chk("be_b_dv_pulse", b_dv, 1'b0);

        // Read-during-write at address 7
        write_enable = 1'b1;
        address_in_w = 4'd7;
        byte_en      = 4'hF;
        data_in      = 32'h0;
        tick;
        byte_en      = 4'b0011;
        data_in      = 32'hFFFFFFFF;
        read_enable  = 1'b1;
        address_in_r = 4'd7;
        tick;
        write_enable = 1'b0;
        chk("rdw_a_old", a_do, 32'h00000000);
        chk("rdw_a_dv", a_dv, 1'b1);
        tick;
        read_enable  = 1'b0;
        chk("rdw_a_next", a_do, 32'h0000FFFF);
        chk("rdw_b_new", b_do, 32'h0000FFFF);
        chk("rdw_b_dv", b_dv, 1'b1);
        tick;
        chk("rdw_b_next", b_do, 32'h0000FFFF);
        chk("rdw_b_next_dv", b_dv, 1'b1);
        chk("rdw_a_idle_dv", a_dv, 1'b0);

        // Throughput: values 0..7 at addresses 0..7
        write_enable = 1'b1;
        byte_en      = 4'hF;
        for (int i = 0; i < 8; i++) begin
            address_in_w = 4'(i);
            data_in      = 32'(i);
            tick;
        end
        write_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address_in_r = 4'(i);
            read_enable  = 1'b1;
            tick;
            chk("tp_a_do", a_do, 32'(i));
            chk("tp_a_dv", a_dv, 1'b1);
            if (i > 0) begin
                chk("tp_b_do", b_do, 32'(i - 1));
                chk("tp_b_dv", b_dv, 1'b1);
            end
        end
        read_enable = 1'b0;
        tick;
        chk("tp_a_end_dv", a_dv, 1'b0);
        chk("tp_b_last_do", b_do, 32'd7);
        chk("tp_b_last_dv", b_dv, 1'b1);
        tick;
        chk("tp_b_end_dv", b_dv, 1'b0);

        // Reset flushes an in-flight read, then abort a sweep at cycle 9
        read_enable  = 1'b1;
        address_in_r = 4'd3;
        tick;
        read_enable  = 1'b0;
        chk("fl_a_do", a_do, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("fl_a_do_rst", a_do, 32'h0);
        chk("fl_a_dv_rst", a_dv, 1'b0);
        chk("fl_b_do_rst", b_do, 32'h0);
        chk("fl_b_dv_rst", b_dv, 1'b0);
        chk("fl_c_do_rst", c_do, 32'h0);
        chk("fl_a_busy_rst", a_busy, 1'b1);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) tick;
        chk("mid_a_busy", a_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_a_do", a_do, 32'h0);
        chk("mid_a_dv", a_dv, 1'b0);
        chk("mid_b_dv", b_dv, 1'b0);
        tick;
        tick;
        rst_n = 1'b1;
        ca = 0; cb = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            tick;
        end
        chk("mid_a_busy_cycles", ca, 16);
        chk("mid_b_busy_cycles", cb, 16);
        chk("mid_a_busy_end", a_busy, 1'b0);

        // Cleared again in A/B; C keeps its contents across reset
        read_enable  = 1'b1;
        address_in_r = 4'd5;
        tick;
        read_enable  = 1'b0;
        chk("post_a_do", a_do, 32'hA5A5A5A5);
        chk("post_c_do", c_do, 32'd5);
        chk("post_c_dv", c_dv, 1'b1);
        tick;
        chk("post_b_do", b_do, 32'hA5A5A5A5);
        chk("c_busy_never", c_busy_seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_ram_sdp_be.md
# sync_ram_sdp_be

Parametrised simple-dual-port block RAM with per-byte write enables, selectable read-during-write behaviour, an optional output pipeline register, a read-valid flag, and a post-reset clear sequencer. It is the next-generation memory primitive for the arch test suite. It targets the same block-RAM inference flow as the existing single-port, simple-dual-port and mixed-width RAMs, and adds the features those lack: byte enables, transparency control, read qualification and a deterministic power-up state.

## Interface
Parameters:
- DATA_WIDTH, default 32: word width; must be a multiple of BYTE_WIDTH.
- ADDRESS_WIDTH, default 10: depth = 2**ADDRESS_WIDTH words.
- BYTE_WIDTH, default 8: lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- RDW_MODE, default 0: same-address read-during-write result; 0 = old data, 1 = new (transparent) data.
- OUT_REG, default 0: 1 adds one output register stage.
- CLEAR_ON_RESET, default 1: 1 = sweep CLEAR_VALUE into every word after reset.
- CLEAR_VALUE, default 0: word written by the clear sweep.

Ports (reset is asynchronous and active-low; one clock):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  async active-low reset.
- write_enable  in  1  write strobe.
- byte_en  in  NB  per-lane write mask; lane i = data_in[i*BYTE_WIDTH +: BYTE_WIDTH].
- address_in_w  in  ADDRESS_WIDTH  write address.
- data_in  in  DATA_WIDTH  write data.
- read_enable  in  1  read strobe.
- address_in_r  in  ADDRESS_WIDTH  read address.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds the result of a read this cycle.
- busy  out  1  clear sweep in progress; port accesses ignored.

## Operation
- Memory array is never reset by rst_n. Contents survive reset when CLEAR_ON_RESET=0.
- Write: on a clk edge with write_enable=1 and busy=0, each lane with byte_en[i]=1 is updated. Other lanes are untouched. byte_en=0 is a no-op.
- Read: on a clk edge with read_enable=1 and busy=0, the word at address_in_r is captured.
- Read-during-write to the same address, same edge:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: enabled lanes from data_in, all other lanes old.
  - Different addresses never interact.
- data_out holds its last value when no read completes. It is never cleared except by rst_n.
- Clear FSM states: IDLE and CLEAR.
  - While rst_n=0: state = CLEAR if CLEAR_ON_RESET else IDLE; counter = 0.
  - In CLEAR, each edge writes CLEAR_VALUE (all lanes) to counter, then increments counter.
  - When counter = 2**ADDRESS_WIDTH-1 is written, state -> IDLE.
  - Counter is ADDRESS_WIDTH+1 bits wide, so there is no wrap ambiguity.
- busy = (state == CLEAR), a direct combinational decode of state.
- While busy, write_enable and read_enable are ignored and no read enters the pipeline.
- rst_n asserted mid-sweep aborts the sweep. It restarts from address 0 after release.

## Timing
- Reset values:
  - data_out = 0.
  - data_valid = 0.
  - busy = CLEAR_ON_RESET.
  - Output pipeline stage = 0, valid = 0.
- Read latency, from the edge that samples read_enable to data_out/data_valid:
  - 1 cycle when OUT_REG=0.
  - 2 cycles when OUT_REG=1.
- data_valid is a single-cycle pulse per accepted read. Back-to-back reads give back-to-back valid data, one per cycle, at full throughput.
- Write visibility: a write on edge N is readable by a read sampled on edge N+1. On edge N itself, RDW_MODE applies.
- The clear sweep lasts exactly 2**ADDRESS_WIDTH edges after rst_n deasserts. busy falls after the last clear write. The first accepted access is on the following edge.
- Reads issued before reset remain in flight only until rst_n asserts. Reset flushes all valid flags.

## Test plan
- Clear sweep (ADDRESS_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5):
  - Release rst_n, hold read_enable=1 at address 3 -> busy high for exactly 16 cycles, data_valid stays 0 throughout.
  - Then read 0..15 -> every word = A5A5A5A5.
- Byte enables:
  - Write 32'h11223344 to address 5 with byte_en=4'b1111.
  - Then write 32'hAABBCCDD to address 5 with byte_en=4'b0101.
  - Read address 5 -> 32'h11BB33DD, data_valid high 1 cycle after the read (2 cycles with OUT_REG=1).
- Read-during-write: address 7 holds 32'h0, then same-edge write 32'hFFFFFFFF (byte_en=4'b0011) and read of address 7 ->
  - RDW_MODE=0 returns 32'h00000000.
  - RDW_MODE=1 returns 32'h0000FFFF.
  - The next read of address 7 returns 32'h0000FFFF in both modes.
- Throughput: 8 consecutive reads of addresses 0..7 holding values 0..7 -> 8 consecutive data_valid cycles, data_out = 0..7 in order, latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
- Reset mid-sweep:
  - Assert rst_n=0 at sweep cycle 9 for 2 cycles -> data_out = 0 and data_valid = 0 immediately.
  - After release, busy lasts a full 16 cycles again.
- Accesses ignored while busy: write 32'h12345678 to address 2 during the sweep -> after the sweep, address 2 reads CLEAR_VALUE.
- CLEAR_ON_RESET=0: busy never asserts.
